// File: rtl/exe_wb_arbiter_if.sv
// exe_wb_arbiter_if: bundle between the functional units/writeback stage and the writeback arbiter.
// Signal suffixes are relative to the arbiter, which takes the slave modport.
interface exe_wb_arbiter_if #(
    parameter int NUM_UNITS  = 4,
    parameter int DATA_W     = 64,
    parameter int RD_W       = 5,
    parameter int FIFO_DEPTH = 2
);
    localparam int UID_W = $clog2(NUM_UNITS);
    localparam int CNT_W = $clog2(NUM_UNITS * FIFO_DEPTH + 2);

    logic                        kill_i;
    logic [NUM_UNITS-1:0]        unit_valid_i;
    logic [NUM_UNITS*RD_W-1:0]   unit_rd_i;
    logic [NUM_UNITS*DATA_W-1:0] unit_data_i;
    logic [NUM_UNITS-1:0]        unit_ready_o;
    logic                        wb_valid_o;
    logic [RD_W-1:0]             wb_rd_o;
    logic [DATA_W-1:0]           wb_data_o;
    logic [UID_W-1:0]            wb_unit_o;
    logic                        wb_ready_i;
    logic                        stall_o;
    logic [CNT_W-1:0]            pending_o;

    modport master (
        output kill_i, unit_valid_i, unit_rd_i, unit_data_i, wb_ready_i,
        input  unit_ready_o, wb_valid_o, wb_rd_o, wb_data_o, wb_unit_o, stall_o, pending_o
    );

    modport slave (
        input  kill_i, unit_valid_i, unit_rd_i, unit_data_i, wb_ready_i,
        output unit_ready_o, wb_valid_o, wb_rd_o, wb_data_o, wb_unit_o, stall_o, pending_o
    );
endinterface

// File: rtl/exe_wb_arbiter.sv
// exe_wb_arbiter: per-unit completion FIFOs drained round-robin into one registered writeback port.
// Kill flushes all buffered results; reset additionally clears the round-robin pointer.
module exe_wb_arbiter #(
    parameter int NUM_UNITS  = 4,
    parameter int DATA_W     = 64,
    parameter int RD_W       = 5,
    parameter int FIFO_DEPTH = 2
) (
    input logic clk_i,
    input logic rst_i,
    exe_wb_arbiter_if.slave bus
);
    localparam int UID_W = $clog2(NUM_UNITS);
    localparam int CNT_W = $clog2(NUM_UNITS * FIFO_DEPTH + 2);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = RD_W + DATA_W;

    logic [ENT_W-1:0]     mem_q    [NUM_UNITS][FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q [NUM_UNITS];
    logic [PTR_W-1:0]     rd_ptr_q [NUM_UNITS];
    logic [OCC_W-1:0]     cnt_q    [NUM_UNITS];
    logic [NUM_UNITS-1:0] ready;
    logic [NUM_UNITS-1:0] push;
    logic [NUM_UNITS-1:0] pop;
    logic [NUM_UNITS-1:0] nonempty;
    logic                 wb_valid_q;
    logic [RD_W-1:0]      wb_rd_q;
    logic [DATA_W-1:0]    wb_data_q;
    logic [UID_W-1:0]     wb_unit_q;
    logic [UID_W-1:0]     rr_ptr_q;
    logic [UID_W-1:0]     rr_ptr_d;
    logic [UID_W-1:0]     grant;
    logic [UID_W-1:0]     cand;
    logic                 grant_vld;
    logic                 load_en;
    logic [ENT_W-1:0]     head;
    logic [CNT_W-1:0]     pending;

    // Ready looks only at the registered count, so a full FIFO refuses a push even while being popped.
    always_comb begin
        ready    = '0;
        nonempty = '0;
        push     = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            ready[k]    = cnt_q[k] < OCC_W'(FIFO_DEPTH);
            nonempty[k] = cnt_q[k] != '0;
            push[k]     = bus.unit_valid_i[k] & ready[k];
        end
    end

    assign load_en = ~wb_valid_q | bus.wb_ready_i;

    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        cand      = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            cand = UID_W'((int'(rr_ptr_q) + i) % NUM_UNITS);
            if (!grant_vld && nonempty[cand]) begin
                grant_vld = 1'b1;
                grant     = cand;
            end
        end
        rr_ptr_d = (int'(grant) == NUM_UNITS - 1) ? '0 : grant + UID_W'(1);
        head     = mem_q[grant][rd_ptr_q[grant]];
    end

    always_comb begin
        pop = '0;
        for (int k = 0; k < NUM_UNITS; k++)
            pop[k] = load_en & grant_vld & (grant == UID_W'(k));
    end

    always_comb begin
        pending = CNT_W'(wb_valid_q);
        for (int k = 0; k < NUM_UNITS; k++)
            pending = pending + CNT_W'(cnt_q[k]);
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NUM_UNITS; k++)
            if (push[k])
                mem_q[k][wr_ptr_q[k]] <= {bus.unit_rd_i[k*RD_W +: RD_W], bus.unit_data_i[k*DATA_W +: DATA_W]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_unit_q  <= '0;
            rr_ptr_q   <= '0;
        end else if (bus.kill_i) begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
            wb_valid_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                if (push[k])
                    wr_ptr_q[k] <= wr_ptr_q[k] + PTR_W'(1);
                if (pop[k])
                    rd_ptr_q[k] <= rd_ptr_q[k] + PTR_W'(1);
                cnt_q[k] <= cnt_q[k] + OCC_W'(push[k]) - OCC_W'(pop[k]);
            end
            if (load_en) begin
                wb_valid_q <= grant_vld;
                if (grant_vld) begin
                    wb_rd_q   <= head[ENT_W-1 -: RD_W];
                    wb_data_q <= head[DATA_W-1:0];
                    wb_unit_q <= grant;
                    rr_ptr_q  <= rr_ptr_d;
                end
            end
        end
    end

    assign bus.unit_ready_o = ready;
    assign bus.stall_o      = ~&ready;
    assign bus.pending_o    = pending;
    assign bus.wb_valid_o   = wb_valid_q;
    assign bus.wb_rd_o      = wb_rd_q;
    assign bus.wb_data_o    = wb_data_q;
    assign bus.wb_unit_o    = wb_unit_q;
endmodule

// File: tb/tb_exe_wb_arbiter.sv
// tb_exe_wb_arbiter: queue-based reference model checked every cycle, plus hand-computed directed checks.
module tb_exe_wb_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int RW = 5;
    localparam int D  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   started = 0;

    always #5 clk = ~clk;

    exe_wb_arbiter_if #(.NUM_UNITS(N), .DATA_W(DW), .RD_W(RW), .FIFO_DEPTH(D)) bus ();

    exe_wb_arbiter #(.NUM_UNITS(N), .DATA_W(DW), .RD_W(RW), .FIFO_DEPTH(D)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per unit, an output slot and a round-robin index.
    logic [RW+DW-1:0] mq [N][$];
    logic             m_v = 1'b0;
    logic [RW-1:0]    m_rd = '0;
    logic [DW-1:0]    m_data = '0;
    int               m_unit = 0;
    int               m_rr = 0;

    always @(posedge clk) begin
        bit rdy [N];
        int g;
        started = 1;
        if (rst) begin
            for (int k = 0; k < N; k++) mq[k].delete();
            m_v = 1'b0; m_rd = '0; m_data = '0; m_unit = 0; m_rr = 0;
        end else if (bus.kill_i) begin
            for (int k = 0; k < N; k++) mq[k].delete();
            m_v = 1'b0;
        end else begin
            for (int k = 0; k < N; k++) rdy[k] = mq[k].size() < D;
            if (!m_v || bus.wb_ready_i) begin
                g = -1;
                for (int i = 0; i < N; i++)
                    if (g < 0 && mq[(m_rr + i) % N].size() > 0) g = (m_rr + i) % N;
                if (g >= 0) begin
                    {m_rd, m_data} = mq[g].pop_front();
                    m_v = 1'b1; m_unit = g; m_rr = (g + 1) % N;
                end else m_v = 1'b0;
            end
            for (int k = 0; k < N; k++)
                if (bus.unit_valid_i[k] && rdy[k])
                    mq[k].push_back({bus.unit_rd_i[k*RW +: RW], bus.unit_data_i[k*DW +: DW]});
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] er;
        int sum;
        if (started) begin
            sum = m_v ? 1 : 0;
            for (int k = 0; k < N; k++) begin
                er[k] = mq[k].size() < D;
                sum += mq[k].size();
            end
            chk("m_valid", 64'(bus.wb_valid_o), 64'(m_v));
            if (m_v) chk("m_unit", 64'(bus.wb_unit_o), 64'(m_unit));
            chk("m_rd", 64'(bus.wb_rd_o), 64'(m_rd));
            chk("m_data", bus.wb_data_o, m_data);
            chk("m_ready", 64'(bus.unit_ready_o), 64'(er));
            chk("m_stall", 64'(bus.stall_o), 64'(er != '1));
            chk("m_pending", 64'(bus.pending_o), 64'(sum));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_unit(input int k, input int rd, input logic [DW-1:0] data);
        bus.unit_valid_i[k] = 1'b1;
        bus.unit_rd_i[k*RW +: RW] = RW'(rd);
        bus.unit_data_i[k*DW +: DW] = data;
    endtask

    task automatic clr();
        bus.unit_valid_i = '0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus.kill_i = 1'b0;
        bus.unit_valid_i = '0;
        bus.unit_rd_i = '0;
        bus.unit_data_i = '0;
        bus.wb_ready_i = 1'b1;
        repeat (2) step();
        chk("rst_valid", 64'(bus.wb_valid_o), 64'd0);
        chk("rst_ready", 64'(bus.unit_ready_o), 64'hF);
        chk("rst_stall", 64'(bus.stall_o), 64'd0);
        chk("rst_pending", 64'(bus.pending_o), 64'd0);
        rst = 1'b0;

        // single result from unit 2
        set_unit(2, 5, 64'hDEAD);
        chk("s_pend0", 64'(bus.pending_o), 64'd0);
        step(); clr();
        chk("s_pend1", 64'(bus.pending_o), 64'd1);
        chk("s_valid1", 64'(bus.wb_valid_o), 64'd0);
        step();
        chk("s_valid2", 64'(bus.wb_valid_o), 64'd1);
        chk("s_rd2", 64'(bus.wb_rd_o), 64'd5);
        chk("s_data2", bus.wb_data_o, 64'hDEAD);
        chk("s_unit2", 64'(bus.wb_unit_o), 64'd2);
        chk("s_pend2", 64'(bus.pending_o), 64'd1);
        step();
        chk("s_valid3", 64'(bus.wb_valid_o), 64'd0);
        chk("s_pend3", 64'(bus.pending_o), 64'd0);

        // same-cycle completion on units 0,1,3
        reset_dut();
        set_unit(0, 1, 64'h100); set_unit(1, 2, 64'h200); set_unit(3, 3, 64'h300);
        step(); clr();
        step();
        chk("m_rd_c2", 64'(bus.wb_rd_o), 64'd1);
        chk("m_unit_c2", 64'(bus.wb_unit_o), 64'd0);
        step();
        chk("m_rd_c3", 64'(bus.wb_rd_o), 64'd2);
        chk("m_unit_c3", 64'(bus.wb_unit_o), 64'd1);
        step();
        chk("m_rd_c4", 64'(bus.wb_rd_o), 64'd3);
        chk("m_unit_c4", 64'(bus.wb_unit_o), 64'd3);
        chk("m_valid_c4", 64'(bus.wb_valid_o), 64'd1);

        // round-robin fairness, units 0 and 1 kept busy
        for (int c = 0; c < 12; c++) begin
            if (c >= 2) begin
                chk("rr_valid", 64'(bus.wb_valid_o), 64'd1);
                chk("rr_unit", 64'(bus.wb_unit_o), 64'(c % 2));
            end
            set_unit(0, c, 64'(c));
            set_unit(1, c + 16, 64'(c + 256));
            step();
        end
        clr();
        repeat (8) step();
        chk("rr_drained", 64'(bus.pending_o), 64'd0);

        // backpressure on unit 0
        reset_dut();
        bus.wb_ready_i = 1'b0;
        set_unit(0, 10, 64'hA0); step();
        set_unit(0, 11, 64'hA1); step();
        set_unit(0, 12, 64'hA2); step();
        chk("bp_ready", 64'(bus.unit_ready_o), 64'hE);
        chk("bp_stall", 64'(bus.stall_o), 64'd1);
        chk("bp_rd", 64'(bus.wb_rd_o), 64'd10);
        chk("bp_pend", 64'(bus.pending_o), 64'd3);
        set_unit(0, 13, 64'hA3); step();
        chk("bp_ready4", 64'(bus.unit_ready_o), 64'hE);
        chk("bp_pend4", 64'(bus.pending_o), 64'd3);
        clr(); bus.wb_ready_i = 1'b1; step();
        chk("bp_rd5", 64'(bus.wb_rd_o), 64'd11);
        chk("bp_pend5", 64'(bus.pending_o), 64'd2);
        step();
        chk("bp_rd6", 64'(bus.wb_rd_o), 64'd12);
        chk("bp_data6", bus.wb_data_o, 64'hA2);
        step();
        chk("bp_valid7", 64'(bus.wb_valid_o), 64'd0);
        chk("bp_pend7", 64'(bus.pending_o), 64'd0);

        // kill with five entries pending and a push on unit 1
        reset_dut();
        bus.wb_ready_i = 1'b0;
        for (int k = 0; k < N; k++) set_unit(k, 20 + k, 64'(k));
        step(); clr();
        set_unit(2, 24, 64'h24); step(); clr();
        chk("k_pend5", 64'(bus.pending_o), 64'd5);
        bus.kill_i = 1'b1;
        set_unit(1, 25, 64'h25); step();
        bus.kill_i = 1'b0; clr();
        chk("k_valid", 64'(bus.wb_valid_o), 64'd0);
        chk("k_pend", 64'(bus.pending_o), 64'd0);
        chk("k_stall", 64'(bus.stall_o), 64'd0);
        chk("k_ready", 64'(bus.unit_ready_o), 64'hF);
        bus.wb_ready_i = 1'b1; step();
        chk("k_lost", 64'(bus.wb_valid_o), 64'd0);
        set_unit(0, 30, 64'h30); set_unit(1, 31, 64'h31); step(); clr();
        step();
        chk("k_rrhold_u", 64'(bus.wb_unit_o), 64'd1);
        chk("k_rrhold_rd", 64'(bus.wb_rd_o), 64'd31);
        step();
        chk("k_next_u", 64'(bus.wb_unit_o), 64'd0);

        // reset beats kill and pushes
        bus.wb_ready_i = 1'b0;
        for (int k = 0; k < N; k++) set_unit(k, 40 + k, 64'(k + 64));
        step();
        rst = 1'b1; bus.kill_i = 1'b1; bus.wb_ready_i = 1'b1;
        set_unit(0, 7, 64'h7); set_unit(1, 8, 64'h8);
        step();
        rst = 1'b0; bus.kill_i = 1'b0; clr();
        chk("r_valid", 64'(bus.wb_valid_o), 64'd0);
        chk("r_rd", 64'(bus.wb_rd_o), 64'd0);
        chk("r_data", bus.wb_data_o, 64'd0);
        chk("r_unit", 64'(bus.wb_unit_o), 64'd0);
        chk("r_pend", 64'(bus.pending_o), 64'd0);
        chk("r_ready", 64'(bus.unit_ready_o), 64'hF);
        repeat (2) step();
        chk("r_valid2", 64'(bus.wb_valid_o), 64'd0);
        chk("r_pend2", 64'(bus.pending_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
